// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, DrawX/DrawY counters, and sync/blank strobes
// delayed by PIPE_DELAY pixels to line up with late-arriving RGB.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_tick,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [1:0]            div_q, div_d;
  logic [9:0]            h_q, h_d;
  logic [9:0]            v_q, v_d;
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0] blank_pipe_q, blank_pipe_d;
  logic                  line_q, line_d;
  logic                  frame_q, frame_d;
  logic                  hs_raw, vs_raw, blank_raw;

  always_comb begin
    pixel_tick = (div_q == DIV_LAST);
    div_d      = pixel_tick ? 2'd0 : div_q + 2'd1;

    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = 10'd0;
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end

    hs_raw    = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vs_raw    = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    blank_raw = (h_q < H_VIS) && (v_q < V_VIS);

    hs_pipe_d       = hs_pipe_q;
    vs_pipe_d       = vs_pipe_q;
    blank_pipe_d    = blank_pipe_q;
    hs_pipe_d[0]    = hs_raw;
    vs_pipe_d[0]    = vs_raw;
    blank_pipe_d[0] = blank_raw;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      hs_pipe_d[i]    = hs_pipe_q[i-1];
      vs_pipe_d[i]    = vs_pipe_q[i-1];
      blank_pipe_d[i] = blank_pipe_q[i-1];
    end

    // Pulses land in the first Clk cycle of the new line/frame.
    line_d  = pixel_tick && (h_q == H_LAST);
    frame_d = line_d && (v_q == V_LAST);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q        <= 2'd0;
      h_q          <= 10'd0;
      v_q          <= 10'd0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      blank_pipe_q <= '0;
      line_q       <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      div_q   <= div_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      if (pixel_tick) begin
        h_q          <= h_d;
        v_q          <= v_d;
        hs_pipe_q    <= hs_pipe_d;
        vs_pipe_q    <= vs_pipe_d;
        blank_pipe_q <= blank_pipe_d;
      end
    end
  end

  assign DrawX       = h_q;
  assign DrawY       = v_q;
  assign VGA_HS      = hs_pipe_q[PIPE_DELAY-1];
  assign VGA_VS      = vs_pipe_q[PIPE_DELAY-1];
  assign VGA_BLANK_N = blank_pipe_q[PIPE_DELAY-1];
  assign VGA_SYNC_N  = 1'b0;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480 timing, and two shrunken
// rasters) checked every cycle against an arithmetic raster model plus directed literals.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic tk_a, hs_a, vs_a, bl_a, sn_a, ln_a, fr_a;
  logic tk_b, hs_b, vs_b, bl_b, sn_b, ln_b, fr_b;
  logic tk_c, hs_c, vs_c, bl_c, sn_c, ln_c, fr_c;

  vga_timing_gen dut_a (
    .Clk(clk), .Reset(rst_a), .DrawX(x_a), .DrawY(y_a), .pixel_tick(tk_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a), .VGA_SYNC_N(sn_a),
    .line_start(ln_a), .frame_start(fr_a));

  vga_timing_gen #(
    .CLK_DIV(1), .PIPE_DELAY(3),
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .Clk(clk), .Reset(rst_b), .DrawX(x_b), .DrawY(y_b), .pixel_tick(tk_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sn_b),
    .line_start(ln_b), .frame_start(fr_b));

  vga_timing_gen #(
    .CLK_DIV(3), .PIPE_DELAY(2),
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_c (
    .Clk(clk), .Reset(rst_c), .DrawX(x_c), .DrawY(y_c), .pixel_tick(tk_c),
    .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_BLANK_N(bl_c), .VGA_SYNC_N(sn_c),
    .line_start(ln_c), .frame_start(fr_c));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Raster as a function of Clk cycles c since the reset edge:
  // pixel p = c/D, position from p, strobes are the raw decode of pixel p-PD.
  function automatic logic [26:0] model(input int c, input int d, input int pd,
                                        input int hv, input int hf, input int hsw, input int hb,
                                        input int vv, input int vf, input int vsw, input int vb);
    int ht, vt, p, x, y, q, qx, qy;
    logic tk, hs, vs, bl, ln, fr;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = c / d;
    x  = p % ht;
    y  = (p / ht) % vt;
    tk = ((c % d) == d - 1);
    hs = 1'b1; vs = 1'b1; bl = 1'b0;
    if (p >= pd) begin
      q  = p - pd;
      qx = q % ht;
      qy = (q / ht) % vt;
      hs = !(qx >= hv + hf && qx < hv + hf + hsw);
      vs = !(qy >= vv + vf && qy < vv + vf + vsw);
      bl = (qx < hv) && (qy < vv);
    end
    ln = ((c % d) == 0) && (p > 0) && ((p % ht) == 0);
    fr = ((c % d) == 0) && (p > 0) && ((p % (ht * vt)) == 0);
    return {10'(x), 10'(y), tk, hs, vs, bl, ln, fr, 1'b0};
  endfunction

  int ca = 0, cb = 0, cc = 0;
  bit va = 0, vb = 0, vc = 0;
  logic sa, sb, sc;

  always @(posedge clk) begin
    sa = rst_a; sb = rst_b; sc = rst_c;
    #1;
    if (sa) begin ca = 0; va = 1; end else ca++;
    if (sb) begin cb = 0; vb = 1; end else cb++;
    if (sc) begin cc = 0; vc = 1; end else cc++;
    if (va) chk("cycle_a", {5'd0, x_a, y_a, tk_a, hs_a, vs_a, bl_a, ln_a, fr_a, sn_a},
                {5'd0, model(ca, 2, 1, 640, 16, 96, 48, 480, 10, 2, 33)});
    if (vb) chk("cycle_b", {5'd0, x_b, y_b, tk_b, hs_b, vs_b, bl_b, ln_b, fr_b, sn_b},
                {5'd0, model(cb, 1, 3, 16, 2, 4, 3, 8, 1, 2, 2)});
    if (vc) chk("cycle_c", {5'd0, x_c, y_c, tk_c, hs_c, vs_c, bl_c, ln_c, fr_c, sn_c},
                {5'd0, model(cc, 3, 2, 16, 2, 4, 3, 8, 1, 2, 2)});
  end

  int hs_fall = -1, hs_rise = -1;
  int bl_rise = -1, bl_fall = -1;
  int vs_fall = -1, vs_rise = -1;
  int nln_b = 0, nfr_b = 0, nln_c = 0, nfr_c = 0;
  bit found;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_drawx", 32'(x_a), 32'd0);
    chk("rst_drawy", 32'(y_a), 32'd0);
    chk("rst_hs", 32'(hs_a), 32'd1);
    chk("rst_vs", 32'(vs_a), 32'd1);
    chk("rst_blank", 32'(bl_a), 32'd0);
    chk("rst_pulses", {30'd0, ln_a, fr_a}, 32'd0);
    chk("sync_n", 32'(sn_a), 32'd0);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int n = 1; n <= 1700; n++) begin
      @(negedge clk);
      if (n == 1) chk("first_tick_a", 32'(tk_a), 32'd1);
      if (n == 2) chk("second_cycle_a", {22'd0, x_a, tk_a}, {22'd0, 10'd1, 1'b0});
      if (n == 1599) chk("line_end_a", {12'd0, x_a, y_a}, {12'd0, 10'd799, 10'd0});
      if (n == 1600) chk("line_wrap_a", {11'd0, x_a, y_a, ln_a}, {11'd0, 10'd0, 10'd1, 1'b1});
      if (hs_fall < 0 && !hs_a) hs_fall = n;
      if (hs_fall >= 0 && hs_rise < 0 && hs_a) hs_rise = n;
      if (bl_rise < 0 && bl_b) bl_rise = n;
      if (bl_rise >= 0 && bl_fall < 0 && !bl_b) bl_fall = n;
      if (vs_fall < 0 && !vs_b) vs_fall = n;
      if (vs_fall >= 0 && vs_rise < 0 && vs_b) vs_rise = n;
      if (n <= 325) begin
        nln_b += int'(ln_b);
        nfr_b += int'(fr_b);
        chk("tick_b_const", 32'(tk_b), 32'd1);
      end
      if (n == 324) chk("corner_b", {12'd0, x_b, y_b}, {12'd0, 10'd24, 10'd12});
      if (n == 325) chk("wrap_b", {10'd0, x_b, y_b, ln_b, fr_b}, {10'd0, 10'd0, 10'd0, 1'b1, 1'b1});
      if (fr_b && ln_b == 1'b0) chk("frame_implies_line_b", 32'(ln_b), 32'd1);
      nln_c += int'(ln_c);
      nfr_c += int'(fr_c);
    end
    chk("hs_fall_cycle", 32'(hs_fall), 32'd1314);
    chk("hs_rise_cycle", 32'(hs_rise), 32'd1506);
    chk("hs_low_width", 32'(hs_rise - hs_fall), 32'd192);
    chk("blank_rise_b", 32'(bl_rise), 32'd3);
    chk("blank_fall_b", 32'(bl_fall), 32'd19);
    chk("vs_fall_b", 32'(vs_fall), 32'd228);
    chk("vs_low_width_b", 32'(vs_rise - vs_fall), 32'd50);
    chk("line_count_b", 32'(nln_b), 32'd13);
    chk("frame_count_b", 32'(nfr_b), 32'd1);
    chk("line_count_c", 32'(nln_c), 32'd22);
    chk("frame_count_c", 32'(nfr_c), 32'd1);

    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (x_b == 10'd20 && y_b == 10'd7) found = 1;
    end
    chk("midframe_reach", 32'(found), 32'd1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("midrst_xy", {12'd0, x_b, y_b}, 32'd0);
    chk("midrst_strobes", {29'd0, hs_b, vs_b, bl_b}, 32'b110);
    chk("midrst_pulses", {30'd0, ln_b, fr_b}, 32'd0);
    repeat (25) @(negedge clk);
    chk("midrst_resume", {11'd0, x_b, y_b, ln_b}, {11'd0, 10'd0, 10'd1, 1'b1});

    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_rst_a", {10'd0, x_a, y_a, hs_a, bl_a}, {10'd0, 10'd0, 10'd0, 1'b1, 1'b0});
    rst_a = 1'b0;
    repeat (100) @(negedge clk);
    chk("resume_a", 32'(x_a), 32'd50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the display path. Generates the DrawX/DrawY pixel coordinates that the colour mapper consumes.
- Drives the VGA sync and blank strobes: VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N.
- Delays the sync and blank strobes by a programmable number of pixel periods. This keeps them aligned with RGB that arrives late because of synchronous sprite-ROM reads.
- Supplies frame and line pulses that game logic uses to step sprite positions once per frame.

Parameters:
- CLK_DIV, 2: Clk cycles per pixel. 50 MHz Clk gives a 25 MHz pixel rate. Legal range 1..4.
- PIPE_DELAY, 1: pixel periods of delay applied to HS/VS/BLANK_N relative to DrawX/DrawY. Legal range 1..4.
- H_VISIBLE, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal timing, in pixels.
- V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical timing, in lines.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800).
- DrawY  out  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525).
- pixel_tick  out  1  one-Clk strobe marking each pixel boundary.
- VGA_HS  out  1  horizontal sync, active low, delayed.
- VGA_VS  out  1  vertical sync, active low, delayed.
- VGA_BLANK_N  out  1  high in the visible region, delayed.
- VGA_SYNC_N  out  1  constant 0.
- line_start  out  1  one-Clk pulse when DrawX wraps to 0.
- frame_start  out  1  one-Clk pulse when DrawX and DrawY both wrap to 0.

Behaviour:
- Single clock domain: Clk. Reset is synchronous and active-high. Everything is registered on posedge Clk; there is no asynchronous reset path.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick = (div_cnt == CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV=1, pixel_tick is held at 1.
- Horizontal counter (drives DrawX):
  - Increments only on a Clk edge where pixel_tick=1.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter (drives DrawY):
  - Increments only on the edge where the horizontal counter wraps.
  - At V_TOTAL-1 it wraps to 0 on that same edge.
- DrawX and DrawY are the raw counter registers and are undelayed. Both hold steady for CLK_DIV Clk cycles.
- Raw strobes, decoded from the counters:
  - hs_raw = 0 iff 656 <= DrawX <= 751.
  - vs_raw = 0 iff 490 <= DrawY <= 491.
  - blank_raw = 1 iff DrawX < 640 and DrawY < 480.
- Delay line:
  - PIPE_DELAY-stage shift register per strobe.
  - Stage 0 loads the raw value; all stages shift only on a pixel_tick edge.
  - VGA_HS, VGA_VS and VGA_BLANK_N are the last stage.
  - Net effect: the outputs lag DrawX/DrawY by exactly PIPE_DELAY pixel periods.
- line_start and frame_start:
  - Registered; high for exactly one Clk cycle on the cycle after the counter edge that produced DrawX=0 (and DrawY=0 for frame_start).
  - frame_start implies line_start in the same cycle.
- Reset, asserted at any point including mid-line or mid-frame; on the next edge:
  - div_cnt = 0, DrawX = 0, DrawY = 0.
  - All delay stages = inactive: HS = 1, VS = 1, BLANK_N = 0.
  - line_start = 0, frame_start = 0.
  - No line_start or frame_start pulse is emitted for the reset itself.
- After reset release:
  - First pixel_tick occurs CLK_DIV-1 cycles later.
  - First frame_start occurs at the first natural wrap, 800*525 pixel periods after release.
- Reset held high: outputs stay at their reset values; counters stay at 0.
- Width rules:
  - Counters are 10-bit unsigned; comparisons are unsigned.
  - H_TOTAL and V_TOTAL are both ≤ 1023, so there is no overflow.
  - Counters never hold values ≥ H_TOTAL or ≥ V_TOTAL.

Test Plan:
- Reset, then 2000 Clk cycles (CLK_DIV=2):
  - pixel_tick high on odd cycles only.
  - DrawX goes 0,0,1,1,2,2,...
  - DrawY stays 0 until DrawX wraps 799→0, which happens 1600 Clk cycles after reset release; DrawY then = 1.
- Horizontal sync, PIPE_DELAY=1:
  - VGA_HS falls exactly one pixel period after DrawX becomes 656.
  - It rises one pixel period after DrawX becomes 752.
  - Low width = 96 pixels = 192 Clk cycles.
- Vertical timing over one full frame:
  - VGA_VS is low for exactly 2 lines (1600 pixels), starting one pixel after DrawY=490, DrawX=0.
  - frame_start pulses once per 420000 pixel periods.
  - line_start pulses 525 times per frame.
- Blanking, PIPE_DELAY=3:
  - VGA_BLANK_N rises 3 pixels after (DrawX,DrawY) = (0,0).
  - It falls 3 pixels after DrawX = 640.
  - It stays 0 for all of DrawY = 480..524.
- Mid-frame reset at DrawX=700, DrawY=300, held 1 cycle:
  - Next cycle: DrawX=0, DrawY=0, HS=1, VS=1, BLANK_N=0, no frame_start.
  - Counting resumes cleanly.
- Wrap and corner case, CLK_DIV=1:
  - pixel_tick is constantly 1.
  - At (799,524), the next edge gives (0,0) with frame_start=1 and line_start=1 in the same cycle.
